call_ret_stack: RTL and testbench
=================================

// Module: call_ret_stack
// PURPOSE
//  Return-address stack fed by the jump decoder's pushCallStack/popCallStack outputs.
//  Calls push the sequential return IP; returns pop it and supply the predicted target to fetch.
//  Every operation exports a checkpoint, so the stack can be rewound on a branch flush.
// PARAMETERS
//  DEPTH     16  number of return-address entries (power of 2, >=4)
//  IP_WIDTH  48  width of a stored return IP
//  PTR_W     $clog2(DEPTH)  top-pointer width (derived, not overridable)
// PORTS
//  clk            in   1         clock, all state updates on posedge
//  rst            in   1         synchronous active-low reset (sampled at posedge clk)
//  stall          in   1         1 = ignore push/pop this cycle (restore still honoured)
//  pushCallStack  in   1         call decoded: push pushAddr
//  popCallStack   in   1         return decoded: pop top entry
//  pushAddr       in   IP_WIDTH  return IP (address after the call)
//  restore        in   1         flush: rewind to the checkpoint on rstr*
//  rstrPtr        in   PTR_W     checkpointed top pointer
//  rstrCnt        in   PTR_W+1   checkpointed occupancy
//  rstrTop        in   IP_WIDTH  checkpointed top entry value
//  topAddr        out  IP_WIDTH  predicted return target = mem[ptr] (combinational)
//  topValid       out  1         cnt!=0
//  ckptPtr        out  PTR_W     current ptr (pre-update state)
//  ckptCnt        out  PTR_W+1   current cnt (pre-update state)
//  ckptTop        out  IP_WIDTH  current mem[ptr]
//  overflow       out  1         registered pulse: push dropped the oldest entry
//  underflow      out  1         registered pulse: pop while empty
// BEHAVIOUR
//  - State: ptr (top index), cnt (0..DEPTH), mem[DEPTH]. Reads are combinational; updates take effect at the next posedge.
//  - Reset (rst==0 at posedge): ptr=0, cnt=0, overflow=0, underflow=0; mem is not cleared.
//    topValid=0 the cycle after reset. Reset beats every other input.
//  - Priority: reset > restore > push/pop. A push/pop that coincides with restore is discarded.
//  - restore: ptr<=rstrPtr, cnt<=rstrCnt. The write to mem depends on RAS_REPAIR_EN (see CONFIGURATION).
//  - push only (~stall): ptr<=ptr+1 (mod DEPTH); mem[ptr+1]<=pushAddr; cnt<=min(cnt+1,DEPTH).
//    If cnt==DEPTH, the oldest entry is overwritten and overflow=1 for one cycle.
//  - pop only (~stall): if cnt!=0, ptr<=ptr-1 (mod DEPTH) and cnt<=cnt-1.
//    If cnt==0, no state change and underflow=1 for one cycle.
//  - push+pop in the same cycle (~stall): replace top in place: mem[ptr]<=pushAddr; ptr unchanged.
//    cnt<=max(cnt,1); no overflow or underflow.
//  - stall=1 with no restore: all state held; overflow/underflow=0 next cycle.
//  - Pointer wrap is pure modular arithmetic; cnt saturates at DEPTH and never wraps.
//  - Latency: topAddr reflects a push/pop one cycle after the op. A pop's prediction is topAddr
//    sampled in the same cycle as popCallStack.
// CONFIGURATION
//  RAS_REPAIR_EN defined: restore also writes mem[rstrPtr]<=rstrTop. This repairs a top entry that
//    a wrong-path push clobbered.
//  RAS_REPAIR_EN undefined: restore rewinds only ptr/cnt; rstrTop is ignored and mem is untouched.
// STRUCTURE
//  - Shared package: IP_WIDTH constant; ras_ckpt_t struct {ptr, cnt, top}, carried with
//    branches down the pipe and returned on flush.
//  - Sub-module ras_ram: DEPTH x IP_WIDTH storage, 1 write port, 2 asynchronous read ports
//    (mem[ptr] for topAddr/ckptTop, spare read port for debug).
//  - All control lives in call_ret_stack.
// TESTING
//  - rst=0 for 1 cycle, then pop -> underflow=1 next cycle, topValid=0, ptr=0.
//  - push 0x1000, push 0x2000, pop, pop -> topAddr reads 0x2000 then 0x1000; topValid=0 at the end.
//  - 17 pushes 0x100..0x1100 at DEPTH=16 -> overflow pulse on the 17th, cnt=16;
//    16 pops return 0x1100..0x200, then underflow.
//  - push+pop with pushAddr=0xABC at cnt=3 -> topAddr=0xABC, cnt stays 3.
//    Same at cnt=0 -> cnt=1, topValid=1.
//  - Take ckpt (ptr=2,cnt=3,top=0x300), then push 0x900 and pop twice, then restore.
//    REPAIR_EN: topAddr=0x300, cnt=3. Without REPAIR_EN: ptr/cnt restored, mem[2] unchanged.
//  - restore + push in the same cycle -> the push is discarded. stall=1 + push -> no change.
//    rst=0 mid-sequence -> cnt=0 next cycle.

Source files
------------

// File: rtl/call_ret_stack_pkg.sv
// rtl/call_ret_stack_pkg.sv - shared constants and checkpoint type for the return-address stack
// Purpose: default geometry of the stack and the checkpoint record that travels
//          with each predicted branch and comes back on a flush.
// Contents: RAS_DEPTH, IP_WIDTH, RAS_PTR_W, ras_ckpt_t {ptr, cnt, top}.
package call_ret_stack_pkg;

    localparam int RAS_DEPTH = 16;
    localparam int IP_WIDTH  = 48;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

    typedef struct packed {
        logic [RAS_PTR_W-1:0] ptr;
        logic [RAS_PTR_W:0]   cnt;
        logic [IP_WIDTH-1:0]  top;
    } ras_ckpt_t;

endpackage

// File: rtl/call_ret_stack_if.sv
// rtl/call_ret_stack_if.sv - decoder/flush side bundle of the return-address stack
// Purpose: groups push/pop/restore controls, prediction and checkpoint outputs.
// Modports: master = jump decoder / flush logic (drives controls, reads prediction),
//           slave  = call_ret_stack.
// Debug: dbgIdx/dbgData expose the spare RAM read port.
interface call_ret_stack_if #(
    parameter int DEPTH = call_ret_stack_pkg::RAS_DEPTH
) ();
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IPW   = call_ret_stack_pkg::IP_WIDTH;

    logic             stall;
    logic             pushCallStack;
    logic             popCallStack;
    logic [IPW-1:0]   pushAddr;
    logic             restore;
    logic [PTR_W-1:0] rstrPtr;
    logic [PTR_W:0]   rstrCnt;
    logic [IPW-1:0]   rstrTop;
    logic [IPW-1:0]   topAddr;
    logic             topValid;
    logic [PTR_W-1:0] ckptPtr;
    logic [PTR_W:0]   ckptCnt;
    logic [IPW-1:0]   ckptTop;
    logic             overflow;
    logic             underflow;
    logic [PTR_W-1:0] dbgIdx;
    logic [IPW-1:0]   dbgData;

    modport master (
        output stall, pushCallStack, popCallStack, pushAddr,
               restore, rstrPtr, rstrCnt, rstrTop, dbgIdx,
        input  topAddr, topValid, ckptPtr, ckptCnt, ckptTop,
               overflow, underflow, dbgData
    );

    modport slave (
        input  stall, pushCallStack, popCallStack, pushAddr,
               restore, rstrPtr, rstrCnt, rstrTop, dbgIdx,
        output topAddr, topValid, ckptPtr, ckptCnt, ckptTop,
               overflow, underflow, dbgData
    );
endinterface

// File: rtl/call_ret_stack_ras_ram.sv
// rtl/call_ret_stack_ras_ram.sv - DEPTH x W storage, one write port, two async read ports
// Ports: clk_i; we_i/waddr_i/wdata_i write on posedge;
//        raddr_a_i -> rdata_a_o (top-of-stack), raddr_b_i -> rdata_b_o (debug).
// Contents are not reset.
module ras_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 48,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [W-1:0]  rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [W-1:0]  rdata_b_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/call_ret_stack.sv
// rtl/call_ret_stack.sv - return-address stack with checkpoint/restore
// Purpose: calls push the return IP, returns pop it; topAddr is the predicted
//          return target. Every cycle exports {ptr, cnt, top} as a checkpoint so
//          a branch flush can rewind the stack.
// Ports: clk, rst (sync active-low); ras (call_ret_stack_if.slave) carrying
//        stall/push/pop/pushAddr, restore/rstr*, topAddr/topValid, ckpt*,
//        overflow/underflow pulses and the debug read port.
// Macro: RAS_REPAIR_EN - restore also rewrites mem[rstrPtr] with rstrTop.
module call_ret_stack
    import call_ret_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    call_ret_stack_if.slave ras
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                we;
    logic [PTR_W-1:0]    waddr;
    logic [IP_WIDTH-1:0] wdata;
    logic [IP_WIDTH-1:0] top_data;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        we    = 1'b0;
        waddr = ptr_q;
        wdata = ras.pushAddr;
        if (ras.restore) begin
            // Restore wins over stall and any coinciding push/pop.
            ptr_d = ras.rstrPtr;
            cnt_d = ras.rstrCnt;
`ifdef RAS_REPAIR_EN
            we    = 1'b1;
            waddr = ras.rstrPtr;
            wdata = ras.rstrTop;
`endif
        end else if (!ras.stall) begin
            if (ras.pushCallStack && ras.popCallStack) begin
                // Return immediately followed by a call: overwrite top in place.
                we = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end
            end else if (ras.pushCallStack) begin
                ptr_d = ptr_q + PTR_W'(1);
                we    = 1'b1;
                waddr = ptr_q + PTR_W'(1);
                // When full the write lands on the oldest slot; cnt stays saturated.
                if (cnt_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (ras.popCallStack) begin
                if (cnt_q != '0) begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
        end
    end

`ifndef RAS_REPAIR_EN
    logic unused_rstr_top;
    assign unused_rstr_top = ^ras.rstrTop;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ras_ram #(
        .DEPTH (DEPTH),
        .W     (IP_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .we_i      (we && rst),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (ptr_q),
        .rdata_a_o (top_data),
        .raddr_b_i (ras.dbgIdx),
        .rdata_b_o (ras.dbgData)
    );

    assign ras.topAddr   = top_data;
    assign ras.ckptTop   = top_data;
    assign ras.topValid  = (cnt_q != '0);
    assign ras.ckptPtr   = ptr_q;
    assign ras.ckptCnt   = cnt_q;
    assign ras.overflow  = ovf_q;
    assign ras.underflow = unf_q;
endmodule

// File: tb/tb_call_ret_stack.sv
// tb/tb_call_ret_stack.sv - directed self-checking bench for call_ret_stack
module tb_call_ret_stack;
    import call_ret_stack_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    ras_ckpt_t ck;

    call_ret_stack_if #(.DEPTH(16)) ras_if ();

    call_ret_stack #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .ras (ras_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic ps, input logic pp, input logic [47:0] a);
        ras_if.pushCallStack = ps;
        ras_if.popCallStack  = pp;
        ras_if.pushAddr      = a;
        cyc();
        ras_if.pushCallStack = 1'b0;
        ras_if.popCallStack  = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic do_restore(input logic [3:0] p, input logic [4:0] c, input logic [47:0] t);
        ras_if.restore = 1'b1;
        ras_if.rstrPtr = p;
        ras_if.rstrCnt = c;
        ras_if.rstrTop = t;
        cyc();
        ras_if.restore = 1'b0;
    endtask

    initial begin
        ras_if.stall = 1'b0;
        ras_if.pushCallStack = 1'b0;
        ras_if.popCallStack = 1'b0;
        ras_if.pushAddr = '0;
        ras_if.restore = 1'b0;
        ras_if.rstrPtr = '0;
        ras_if.rstrCnt = '0;
        ras_if.rstrTop = '0;
        ras_if.dbgIdx = '0;

        // Reset state
        do_rst();
        check("rst_valid", ras_if.topValid, 0);
        check("rst_ptr", ras_if.ckptPtr, 0);
        check("rst_cnt", ras_if.ckptCnt, 0);
        check("rst_ovf", ras_if.overflow, 0);
        check("rst_unf", ras_if.underflow, 0);

        // Pop on empty
        do_op(1'b0, 1'b1, 48'h0);
        check("empty_pop_unf", ras_if.underflow, 1);
        check("empty_pop_valid", ras_if.topValid, 0);
        check("empty_pop_ptr", ras_if.ckptPtr, 0);
        cyc();
        check("unf_pulse_end", ras_if.underflow, 0);

        // Two pushes then two pops
        do_op(1'b1, 1'b0, 48'h1000);
        do_op(1'b1, 1'b0, 48'h2000);
        check("pp_top0", ras_if.topAddr, 48'h2000);
        check("pp_cnt0", ras_if.ckptCnt, 2);
        do_op(1'b0, 1'b1, 48'h0);
        check("pp_top1", ras_if.topAddr, 48'h1000);
        check("pp_cnt1", ras_if.ckptCnt, 1);
        do_op(1'b0, 1'b1, 48'h0);
        check("pp_valid_end", ras_if.topValid, 0);
        check("pp_ptr_end", ras_if.ckptPtr, 0);
        check("pp_unf_end", ras_if.underflow, 0);

        // Fill past capacity
        do_rst();
        for (int k = 1; k <= 17; k++) begin
            do_op(1'b1, 1'b0, 48'(k * 256));
            if (k == 16) begin
                check("fill16_ovf", ras_if.overflow, 0);
                check("fill16_cnt", ras_if.ckptCnt, 16);
            end
        end
        check("fill17_ovf", ras_if.overflow, 1);
        check("fill17_cnt", ras_if.ckptCnt, 16);
        check("fill17_ptr", ras_if.ckptPtr, 1);
        for (int i = 0; i < 16; i++) begin
            check("drain_pred", ras_if.topAddr, 64'(48'h1100 - 48'(i * 256)));
            do_op(1'b0, 1'b1, 48'h0);
            if (i == 0) check("drain_ovf_end", ras_if.overflow, 0);
        end
        check("drain_valid", ras_if.topValid, 0);
        do_op(1'b0, 1'b1, 48'h0);
        check("drain_unf", ras_if.underflow, 1);

        // Push+pop replace
        do_rst();
        do_op(1'b1, 1'b0, 48'h100);
        do_op(1'b1, 1'b0, 48'h200);
        do_op(1'b1, 1'b0, 48'h300);
        do_op(1'b1, 1'b1, 48'hABC);
        check("repl_top", ras_if.topAddr, 48'hABC);
        check("repl_cnt", ras_if.ckptCnt, 3);
        check("repl_ptr", ras_if.ckptPtr, 3);
        check("repl_flags", {ras_if.overflow, ras_if.underflow}, 0);
        do_rst();
        do_op(1'b1, 1'b1, 48'hABC);
        check("repl0_cnt", ras_if.ckptCnt, 1);
        check("repl0_valid", ras_if.topValid, 1);
        check("repl0_top", ras_if.topAddr, 48'hABC);
        check("repl0_ptr", ras_if.ckptPtr, 0);

        // Checkpoint and restore
        do_rst();
        do_restore(4'd15, 5'd0, 48'h0);
        check("rs_ptr15", ras_if.ckptPtr, 15);
        do_op(1'b1, 1'b0, 48'h100);
        do_op(1'b1, 1'b0, 48'h200);
        do_op(1'b1, 1'b0, 48'h300);
        check("ck_ptr", ras_if.ckptPtr, 2);
        check("ck_cnt", ras_if.ckptCnt, 3);
        check("ck_top", ras_if.ckptTop, 48'h300);
        ck.ptr = ras_if.ckptPtr;
        ck.cnt = ras_if.ckptCnt;
        ck.top = ras_if.ckptTop;
        do_op(1'b1, 1'b0, 48'h900);
        do_op(1'b0, 1'b1, 48'h0);
        do_op(1'b0, 1'b1, 48'h0);
        check("wp_ptr", ras_if.ckptPtr, 1);
        do_restore(ck.ptr, ck.cnt, ck.top);
        check("rs_top", ras_if.topAddr, 48'h300);
        check("rs_cnt", ras_if.ckptCnt, 3);
        check("rs_ptr", ras_if.ckptPtr, 2);
        // Wrong-path clobber of the checkpointed top slot
        do_op(1'b0, 1'b1, 48'h0);
        do_op(1'b1, 1'b0, 48'h555);
        check("clob_top", ras_if.topAddr, 48'h555);
        do_restore(ck.ptr, ck.cnt, ck.top);
        ras_if.dbgIdx = 4'd2;
        #1;
`ifdef RAS_REPAIR_EN
        check("repair_top", ras_if.topAddr, 48'h300);
        check("repair_mem2", ras_if.dbgData, 48'h300);
`else
        check("norepair_top", ras_if.topAddr, 48'h555);
        check("norepair_mem2", ras_if.dbgData, 48'h555);
`endif
        check("clob_rs_cnt", ras_if.ckptCnt, 3);

        // Restore with simultaneous push: push discarded
        ras_if.dbgIdx = 4'd6;
        ras_if.pushCallStack = 1'b1;
        ras_if.pushAddr = 48'hDEAD;
        do_restore(4'd5, 5'd2, 48'h500);
        ras_if.pushCallStack = 1'b0;
        check("rsp_ptr", ras_if.ckptPtr, 5);
        check("rsp_cnt", ras_if.ckptCnt, 2);
        check("rsp_top", ras_if.topAddr, 48'h500);
        check("rsp_mem6", ras_if.dbgData, 48'h600);

        // Stall holds state
        ras_if.stall = 1'b1;
        do_op(1'b1, 1'b0, 48'hBEEF);
        check("stall_push_ptr", ras_if.ckptPtr, 5);
        check("stall_push_cnt", ras_if.ckptCnt, 2);
        check("stall_push_mem6", ras_if.dbgData, 48'h600);
        do_op(1'b0, 1'b1, 48'h0);
        check("stall_pop_cnt", ras_if.ckptCnt, 2);
        check("stall_pop_unf", ras_if.underflow, 0);
        do_restore(4'd4, 5'd1, 48'h400);
        check("stall_rs_ptr", ras_if.ckptPtr, 4);
        check("stall_rs_cnt", ras_if.ckptCnt, 1);
        check("stall_rs_top", ras_if.topAddr, 48'h400);
        ras_if.stall = 1'b0;

        // Reset mid-sequence beats a push
        do_op(1'b1, 1'b0, 48'h777);
        check("mid_cnt", ras_if.ckptCnt, 2);
        rst = 1'b0;
        do_op(1'b1, 1'b0, 48'h888);
        rst = 1'b1;
        check("midrst_cnt", ras_if.ckptCnt, 0);
        check("midrst_ptr", ras_if.ckptPtr, 0);
        check("midrst_valid", ras_if.topValid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
